// File: rtl/axi_master_arbiter_pkg.sv
//==============================================================================
// Module  : axi_arb_pkg
// Brief   : Shared types and AXI field widths for the AXI master arbiter.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package axi_arb_pkg;

  localparam int NUM_REQ_MAX = 8;

  // AXI field widths, kept in step with the wrapper's core-side port
  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int LEN_WIDTH   = 8;
  localparam int SIZE_WIDTH  = 3;
  localparam int BURST_WIDTH = 2;
  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int RESP_WIDTH  = 2;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_master_arbiter_rr_picker.sv
//==============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin picker: rotate the request vector so the
//           slot after last_grant sits at position 0, then priority-encode.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int GRANT_W = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] winner,
  output logic               found
);

  logic [GRANT_W-1:0] w_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_rot;

  // last_grant + 1 + i never exceeds 2*NUM_REQ-1, so one subtraction wraps it
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      int v_pos;
      v_pos = int'(last_grant) + 1 + i;
      if (v_pos >= NUM_REQ) begin
        v_pos = v_pos - NUM_REQ;
      end
      w_idx[i] = GRANT_W'(v_pos);
      w_rot[i] = req[w_idx[i]];
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        found  = 1'b1;
        winner = w_idx[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_master_arbiter.sv
//==============================================================================
// Module  : axi_master_arbiter
// Brief   : Round-robin sharing of one AXI master wrapper among NUM_REQ
//           requesters, one transaction at a time. Optional macro ARB_LOCK_EN
//           lets a requester keep the grant across back-to-back commands.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GRANT_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            aclk,
  input  logic                            areset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0]   req_size,
  input  logic [NUM_REQ*BURST_WIDTH-1:0]  req_burst,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]   req_strb,
  input  logic [NUM_REQ-1:0]              req_lock,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            resp_last,
  output logic                            resp_err,
  output logic [ADDR_WIDTH-1:0]           write_addr,
  output logic [DATA_WIDTH-1:0]           write_data,
  output logic [LEN_WIDTH-1:0]            write_len,
  output logic [BURST_WIDTH-1:0]          write_burst,
  output logic [STRB_WIDTH-1:0]           write_strb,
  output logic [SIZE_WIDTH-1:0]           write_size,
  output logic                            write_en,
  output logic [ADDR_WIDTH-1:0]           read_addr,
  output logic [LEN_WIDTH-1:0]            read_len,
  output logic [BURST_WIDTH-1:0]          read_burst,
  output logic [SIZE_WIDTH-1:0]           read_size,
  output logic                            read_en,
  input  logic [DATA_WIDTH-1:0]           read_data,
  input  logic                            mon_rhs,
  input  logic                            mon_rlast,
  input  logic [RESP_WIDTH-1:0]           mon_rresp,
  input  logic                            mon_bhs,
  input  logic [RESP_WIDTH-1:0]           mon_bresp,
  output logic [GRANT_W-1:0]              grant_idx
);

  arb_state_t          r_state;
  logic [GRANT_W-1:0]  r_last_grant;
  logic                r_is_write;

  logic [NUM_REQ-1:0]  w_eligible;
  logic [GRANT_W-1:0]  w_winner;
  logic                w_found;
  logic [NUM_REQ-1:0]  w_win_oh;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic                w_rd_hs;
  logic                w_wr_hs;
  logic                w_done;

  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;
  logic [LEN_WIDTH-1:0]   w_sel_len;
  logic [SIZE_WIDTH-1:0]  w_sel_size;
  logic [BURST_WIDTH-1:0] w_sel_burst;
  logic [STRB_WIDTH-1:0]  w_sel_strb;

  assign w_grant_oh = NUM_REQ'(1) << grant_idx;
  assign w_win_oh   = NUM_REQ'(1) << w_winner;

`ifdef ARB_LOCK_EN
  logic r_lock;
  logic r_locked;

  // While locked only the holder of the lock may be picked again
  assign w_eligible = r_locked ? (req_valid & w_grant_oh) : req_valid;
`else
  logic w_unused_lock;

  assign w_eligible    = req_valid;
  assign w_unused_lock = ^req_lock;
`endif

  rr_picker #(
    .NUM_REQ    (NUM_REQ),
    .GRANT_W    (GRANT_W)
  ) u_rr_picker (
    .req        (w_eligible),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .found      (w_found)
  );

  always_comb begin
    w_sel_addr  = req_addr [int'(w_winner)*ADDR_WIDTH  +: ADDR_WIDTH];
    w_sel_wdata = req_wdata[int'(w_winner)*DATA_WIDTH  +: DATA_WIDTH];
    w_sel_len   = req_len  [int'(w_winner)*LEN_WIDTH   +: LEN_WIDTH];
    w_sel_size  = req_size [int'(w_winner)*SIZE_WIDTH  +: SIZE_WIDTH];
    w_sel_burst = req_burst[int'(w_winner)*BURST_WIDTH +: BURST_WIDTH];
    w_sel_strb  = req_strb [int'(w_winner)*STRB_WIDTH  +: STRB_WIDTH];
  end

  // Acceptance is visible only in IDLE and is suppressed while reset is held
  assign req_ready = (areset_n && (r_state == IDLE) && w_found) ? w_win_oh : '0;

  // Handshakes of the wrong type or outside BUSY fall through here untouched
  assign w_rd_hs = (r_state == BUSY) && !r_is_write && mon_rhs;
  assign w_wr_hs = (r_state == BUSY) &&  r_is_write && mon_bhs;
  assign w_done  = (w_rd_hs && mon_rlast) || w_wr_hs;

  assign resp_valid = (w_rd_hs || w_wr_hs) ? w_grant_oh : '0;
  assign resp_data  = w_rd_hs ? read_data : '0;
  assign resp_last  = w_rd_hs ? mon_rlast : w_wr_hs;
  assign resp_err   = w_rd_hs ? (mon_rresp != RESP_OKAY) :
                      w_wr_hs ? (mon_bresp != RESP_OKAY) : 1'b0;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_W'(NUM_REQ - 1);
      r_is_write   <= 1'b0;
      grant_idx    <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_len    <= '0;
      write_burst  <= '0;
      write_strb   <= '1;
      write_size   <= '0;
      write_en     <= 1'b0;
      read_addr    <= '0;
      read_len     <= '0;
      read_burst   <= '0;
      read_size    <= '0;
      read_en      <= 1'b0;
`ifdef ARB_LOCK_EN
      r_lock       <= 1'b0;
      r_locked     <= 1'b0;
`endif
    end else begin
      write_en <= 1'b0;
      read_en  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            grant_idx  <= w_winner;
            r_is_write <= req_write[w_winner];
`ifdef ARB_LOCK_EN
            r_lock     <= req_lock[w_winner];
`endif
            if (req_write[w_winner]) begin
              write_addr  <= w_sel_addr;
              write_data  <= w_sel_wdata;
              write_len   <= w_sel_len;
              write_size  <= w_sel_size;
              write_burst <= w_sel_burst;
              write_strb  <= w_sel_strb;
              write_en    <= 1'b1;
            end else begin
              read_addr   <= w_sel_addr;
              read_len    <= w_sel_len;
              read_size   <= w_sel_size;
              read_burst  <= w_sel_burst;
              read_en     <= 1'b1;
            end
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= BUSY;
        end
        BUSY: begin
          if (w_done) begin
            r_state <= IDLE;
`ifdef ARB_LOCK_EN
            // A locked completion keeps the rotation pointer where it is
            if (r_lock) begin
              r_locked <= 1'b1;
            end else begin
              r_locked     <= 1'b0;
              r_last_grant <= grant_idx;
            end
`else
            r_last_grant <= grant_idx;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
